scroll_ctrl: RTL and testbench

- Generates the 3-bit rotation select that drives the 8-display word-rotator mux stage, so the message scrolls across hex_disp automatically instead of from sw[9:7].
- Contains a prescaler tick generator, a RUN/PAUSE state machine, direction control, and a synchronised single-step key for manual stepping while paused.
- Sits directly upstream of the rotator; sel connects to the rotator's select input.

---
 rtl/scroll_pkg.sv | 17 +
 rtl/scroll_ctrl_if.sv | 23 ++
 rtl/scroll_ctrl_tick_gen.sv | 27 ++
 rtl/scroll_ctrl.sv | 96 +++++++++
 tb/tb_scroll_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/scroll_pkg.sv
// rtl/scroll_pkg.sv - shared types, direction codes and next-position helper for scroll_ctrl
package scroll_pkg;

  typedef enum logic {PAUSE, RUN} scroll_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Next rotation position with explicit wrap so any NUM_POS in 2..8 works
  function automatic int next_sel(input int sel, input logic dir, input int num_pos);
    if (dir == DIR_DOWN) begin
      return (sel == 0) ? num_pos - 1 : sel - 1;
    end
    return (sel == num_pos - 1) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/scroll_ctrl_if.sv
// rtl/scroll_ctrl_if.sv - control inputs and rotation outputs of scroll_ctrl
interface scroll_ctrl_if #(
  parameter int SEL_W = 3
);

  logic             run_en;
  logic             dir;
  logic             step_key_n;
  logic [SEL_W-1:0] sel;
  logic             tick;
  logic             wrap;

  modport master (
    output run_en, dir, step_key_n,
    input  sel, tick, wrap
  );

  modport slave (
    input  run_en, dir, step_key_n,
    output sel, tick, wrap
  );

endinterface

// File: rtl/scroll_ctrl_tick_gen.sv
// rtl/scroll_ctrl_tick_gen.sv - prescaler counting 0..TICK_DIV-1 with terminal-count flag
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic terminal
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_cnt;

  assign terminal = (r_cnt == CW'(TICK_DIV - 1));

  // Count while enabled; clear has priority so a fresh run always starts from zero
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= terminal ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/scroll_ctrl.sv
// rtl/scroll_ctrl.sv - RUN/PAUSE scroll sequencer producing the rotator select
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int NUM_POS  = 8,
  parameter int SEL_W    = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  scroll_ctrl_if.slave   bus
);

  scroll_state_e    r_state;
  logic [SEL_W-1:0] r_sel;
  logic             r_tick;
  logic             r_wrap;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_hist;

  logic             w_run_active;
  logic             w_terminal;
  logic             w_timed_adv;
  logic             w_step_pulse;
  logic             w_step_adv;
  logic             w_adv;
  logic             w_wrap_next;
  logic [SEL_W-1:0] w_sel_next;

  // Prescaler only runs while RUN is both the state and the request; otherwise it sits at zero
  assign w_run_active = (r_state == RUN) && bus.run_en;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_run_active),
    .clr      (!w_run_active),
    .terminal (w_terminal)
  );

  assign w_timed_adv  = w_run_active && w_terminal;
  assign w_step_pulse = !r_sync2 && r_hist;
  assign w_step_adv   = w_step_pulse && (r_state == PAUSE) && !bus.run_en;
  assign w_adv        = w_timed_adv || w_step_adv;
  assign w_sel_next   = SEL_W'(next_sel(int'(r_sel), bus.dir, NUM_POS));
  assign w_wrap_next  = (bus.dir == DIR_UP) ? (r_sel == SEL_W'(NUM_POS - 1)) : (r_sel == '0);

  // Key synchroniser plus history flop; all reset to released so a reset drops any edge in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= bus.step_key_n;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // RUN/PAUSE state follows run_en with one edge of latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= PAUSE;
    end else begin
      case (r_state)
        PAUSE:   if (bus.run_en)  r_state <= RUN;
        RUN:     if (!bus.run_en) r_state <= PAUSE;
        default: r_state <= PAUSE;
      endcase
    end
  end

  // Registered select with tick/wrap pulses coincident with the new value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= w_timed_adv;
      r_wrap <= w_adv && w_wrap_next;
      if (w_adv) begin
        r_sel <= w_sel_next;
      end
    end
  end

  assign bus.sel  = r_sel;
  assign bus.tick = r_tick;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_scroll_ctrl.sv
// tb/tb_scroll_ctrl.sv - randomized and directed bench for scroll_ctrl with a behavioural model
module tb_scroll_ctrl;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  scroll_ctrl_if #(.SEL_W(3)) ifc0 ();
  scroll_ctrl_if #(.SEL_W(3)) ifc1 ();

  scroll_ctrl #(.TICK_DIV(TD), .NUM_POS(8), .SEL_W(3)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc0)
  );

  scroll_ctrl #(.TICK_DIV(TD), .NUM_POS(6), .SEL_W(3)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: positions live on a ring of size m_num; run time is measured in edges since RUN began
  int m_num  [2] = '{8, 6};
  int m_sel  [2];
  int m_tick [2];
  int m_wrap [2];
  bit m_run;
  int m_phase;
  bit k_last [3];
  bit m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag);
    check({tag, ".sel0"},  ifc0.sel,  m_sel[0]);
    check({tag, ".tick0"}, ifc0.tick, m_tick[0]);
    check({tag, ".wrap0"}, ifc0.wrap, m_wrap[0]);
    check({tag, ".sel1"},  ifc1.sel,  m_sel[1]);
    check({tag, ".tick1"}, ifc1.tick, m_tick[1]);
    check({tag, ".wrap1"}, ifc1.wrap, m_wrap[1]);
  endtask

  task automatic model_edge(input bit rst, input bit run, input bit d, input bit key);
    bit adv_t;
    bit adv_s;
    bit fell;
    int nxt;
    if (!rst) begin
      m_run   = 1'b0;
      m_phase = 0;
      for (int i = 0; i < 2; i++) begin
        m_sel[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
      end
      for (int j = 0; j < 3; j++) k_last[j] = 1'b1;
    end else begin
      // key seen high then low, two and one edges before the previous sample
      fell  = (k_last[1] == 1'b0) && (k_last[2] == 1'b1);
      adv_t = 1'b0;
      adv_s = 1'b0;
      if (m_run && run) begin
        m_phase++;
        if (m_phase == TD) begin
          adv_t   = 1'b1;
          m_phase = 0;
        end
      end else if (m_run) begin
        m_run = 1'b0; m_phase = 0;
      end else if (run) begin
        m_run = 1'b1; m_phase = 0;
      end else begin
        adv_s = fell;
      end
      for (int i = 0; i < 2; i++) begin
        m_tick[i] = adv_t;
        m_wrap[i] = 0;
        if (adv_t || adv_s) begin
          nxt = d ? (m_sel[i] + m_num[i] - 1) % m_num[i] : (m_sel[i] + 1) % m_num[i];
          m_wrap[i] = (!d && nxt == 0) || (d && nxt == m_num[i] - 1);
          m_sel[i]  = nxt;
        end
      end
      k_last[2] = k_last[1];
      k_last[1] = k_last[0];
      k_last[0] = key;
    end
  endtask

  task automatic cyc(input bit rst, input bit run, input bit d, input bit key, input string tag);
    @(negedge clk);
    if (m_valid) check_now(tag);
    rst_n           = rst;
    ifc0.run_en     = run;  ifc1.run_en     = run;
    ifc0.dir        = d;    ifc1.dir        = d;
    ifc0.step_key_n = key;  ifc1.step_key_n = key;
    model_edge(rst, run, d, key);
    m_valid = 1'b1;
  endtask

  initial begin
    bit r_run, r_dir, r_key, r_rst;

    // reset
    repeat (2) cyc(0, 0, 0, 1, "reset");
    // auto-scroll up, both position counts
    repeat (40) cyc(1, 1, 0, 1, "up");
    // auto-scroll down from reset
    cyc(0, 0, 0, 1, "rst_dn");
    repeat (14) cyc(1, 1, 1, 1, "down");
    // manual steps while paused, held key gives one step
    cyc(0, 0, 0, 1, "rst_step");
    repeat (3) begin
      repeat (10) cyc(1, 0, 0, 0, "step_lo");
      repeat (10) cyc(1, 0, 0, 1, "step_hi");
    end
    // key activity ignored while running
    for (int i = 0; i < 30; i++) cyc(1, 1, 0, (i / 3) % 2 == 0, "run_key");
    // drop run_en in the terminal-count cycle, then resume
    cyc(0, 0, 0, 1, "rst_tc");
    repeat (4) cyc(1, 1, 0, 1, "tc_run");
    cyc(1, 0, 0, 1, "tc_drop");
    repeat (10) cyc(1, 1, 0, 1, "tc_resume");
    // reset in RUN at sel=5 with a key edge in flight
    cyc(0, 0, 0, 1, "rst_mid0");
    repeat (21) cyc(1, 1, 0, 1, "to5");
    cyc(1, 1, 0, 0, "key_fly");
    cyc(0, 0, 0, 1, "rst_mid");
    repeat (8) cyc(1, 0, 0, 1, "post_rst");
    // randomized traffic
    r_run = 0; r_dir = 0; r_key = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) r_run = ~r_run;
      if ($urandom_range(9) == 0)  r_dir = ~r_dir;
      if ($urandom_range(3) == 0)  r_key = ~r_key;
      r_rst = ($urandom_range(199) != 0);
      cyc(r_rst, r_run, r_dir, r_key, "rnd");
    end
    @(negedge clk);
    check_now("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
